mac_learn_ctrl: RTL and testbench
=================================

# mac_learn_ctrl

MAC address learning and lookup controller for the L2 switch forwarding table. Owns the CAM write and compare ports, accepts learn requests (source MAC + ingress port) and lookup requests (destination MAC), allocates or evicts CAM entries, and keeps a per-entry egress-port table. It sits directly upstream of `cam` (instantiated with DATA_WIDTH=48) and downstream of the frame parser.

## Interface
- ADDR_WIDTH, 5, log2 table entries; must equal the CAM's ADDR_WIDTH.
- PORT_WIDTH, 2, switch port number width.
- CAM_MATCH_LATENCY, 1, cycles from cam_compare_data change to valid cam_match/cam_match_addr (≥1).
- AGE_PERIOD, 50000000, cycles between aging sweeps (only with aging compiled in).
- clk  in  1  single clock; every register is clocked on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- learn_mac  in  48  source MAC; bit 40 is the I/G bit.
- learn_port  in  PORT_WIDTH  ingress port.
- learn_valid / learn_ready  in / out  1  learn handshake.
- lookup_mac  in  48  destination MAC.
- lookup_valid / lookup_ready  in / out  1  lookup handshake.
- resp_valid  out  1  one-cycle lookup result pulse; no backpressure.
- resp_hit  out  1  lookup hit.
- resp_port  out  PORT_WIDTH  egress port on a hit; 0 on a miss.
- cam_write_addr / cam_write_data / cam_write_delete / cam_write_enable  out  ADDR_WIDTH/48/1/1  to CAM write port.
- cam_write_busy  in  1  from CAM.
- cam_compare_data  out  48  to CAM.
- cam_match  in  1, cam_match_addr  in  ADDR_WIDTH  from CAM.

## Operation
- State: valid[2**ADDR_WIDTH], port_mem[2**ADDR_WIDTH], round-robin evict pointer rr (ADDR_WIDTH bits).
- FSM: IDLE, CMP, DECIDE, WRITE, WAIT_BUSY, plus AGE (aging only).
- IDLE: the ready signals are high only in IDLE. Arbitration priority is lookup > learn > age sweep, so at most one request is accepted per cycle. On a handshake, register the MAC into cam_compare_data and go to CMP.
- CMP: wait CAM_MATCH_LATENCY cycles, then go to DECIDE.
- DECIDE, lookup: pulse resp_valid with resp_hit=cam_match and resp_port=port_mem[cam_match_addr], then return to IDLE.
- DECIDE, learn with the I/G bit set: drop the request and return to IDLE; nothing is written.
- DECIDE, learn hit: set port_mem[cam_match_addr]=learn_port (station move or refresh), with no CAM write. Return to IDLE.
- DECIDE, learn miss: target is the lowest address with valid=0. If the table is full, target is rr and rr increments, wrapping from 2**ADDR_WIDTH-1 to 0. Go to WRITE.
- WRITE: assert cam_write_enable for exactly one cycle with cam_write_delete=0, the target address and the MAC. Go to WAIT_BUSY.
- WAIT_BUSY: stay at least one cycle, then until cam_write_busy=0. On exit set valid[target]=1 and port_mem[target]=learn_port, then go to IDLE.
- Requests are never dropped except I/G-bit learns.

## Timing
- Reset values: learn_ready=0, lookup_ready=0, resp_valid=0, resp_hit=0, resp_port=0, all cam_write_* outputs 0, cam_compare_data=0, valid all 0, rr=0, FSM=IDLE. The ready signals rise the first cycle after rst deasserts.
- Lookup accepted at edge T: resp_valid is high in cycle T+CAM_MATCH_LATENCY+2 (T+3 at the default). lookup_ready stays low until the cycle after resp_valid.
- Learn hit or drop: ready returns CAM_MATCH_LATENCY+3 cycles after acceptance.
- Learn miss: ready returns no earlier than WRITE+2 and is bounded by cam_write_busy.
- Reset asserted mid-operation aborts immediately: cam_write_enable drops, and no partial valid/port update survives.
- A lookup of a MAC whose learn write is in progress returns a miss, because lookups are not accepted until WAIT_BUSY exits.

## Configuration
- MAC_LEARN_AGING_EN defined:
  - A per-entry hit flag is set on every learn hit and learn write.
  - An AGE_PERIOD counter raises a pending sweep. The sweep starts from IDLE at lowest priority and visits addresses 0..2**ADDR_WIDTH-1, one per AGE step.
  - For an entry with valid=1 and hit=0: issue a CAM write with cam_write_delete=1, wait on busy, then clear valid.
  - For an entry with hit=1: clear hit.
  - Between addresses the sweep returns to IDLE, so pending lookups and learns interleave.
- MAC_LEARN_AGING_EN undefined: no counter, no hit flags, no AGE state; entries persist until evicted.

## Test plan
- Reset, then learn 00:11:22:33:44:55 on port 2 -> CAM write to address 0, write_delete=0; a later lookup of the same MAC -> resp_valid at T+3, hit=1, port=2.
- Lookup of unknown 00:00:00:00:00:99 -> resp_hit=0, resp_port=0, and no cam_write_enable.
- Learn 01:00:5E:00:00:01 (I/G set) -> no CAM write; ready returns after 4 cycles.
- Relearn the address 0 MAC on port 3 -> no CAM write; lookup returns port 3.
- Fill 32 entries, then learn a 33rd MAC -> written to address 0 (rr=0, then rr=1); a lookup of the old address 0 MAC misses. Hold cam_write_busy high 10 cycles -> ready stays low throughout.
- With MAC_LEARN_AGING_EN and AGE_PERIOD=100: learn a MAC with no refresh -> cam_write_delete=1 issued on the second sweep, and the subsequent lookup misses.

Source files
------------

// File: rtl/mac_learn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mac_learn_ctrl
// Brief    : L2 MAC learn/lookup controller that owns the CAM write and
//            compare ports. Aging sweep is built only with MAC_LEARN_AGING_EN.
// Revision : 1.0
// ============================================================================
module mac_learn_ctrl #(
    parameter int ADDR_WIDTH        = 5,
    parameter int PORT_WIDTH        = 2,
    parameter int CAM_MATCH_LATENCY = 1,
    parameter int AGE_PERIOD        = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [47:0]           learn_mac,
    input  logic [PORT_WIDTH-1:0] learn_port,
    input  logic                  learn_valid,
    output logic                  learn_ready,
    input  logic [47:0]           lookup_mac,
    input  logic                  lookup_valid,
    output logic                  lookup_ready,
    output logic                  resp_valid,
    output logic                  resp_hit,
    output logic [PORT_WIDTH-1:0] resp_port,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [47:0]           cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [47:0]           cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr
);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int CNT_W  = (CAM_MATCH_LATENCY > 1) ? $clog2(CAM_MATCH_LATENCY) : 1;
    localparam int IG_BIT = 40;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CMP       = 3'd1;
    localparam logic [2:0] S_DECIDE    = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_WAIT_BUSY = 3'd4;
    localparam logic [2:0] S_AGE       = 3'd5;

    localparam logic [1:0] OP_LOOKUP = 2'd0;
    localparam logic [1:0] OP_LEARN  = 2'd1;
`ifdef MAC_LEARN_AGING_EN
    localparam logic [1:0] OP_AGE    = 2'd2;
`endif

    logic [2:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_hit_q, resp_hit_d;
    logic [PORT_WIDTH-1:0] resp_port_q, resp_port_d;
    logic [47:0]           cmp_data_q, cmp_data_d;
    logic [PORT_WIDTH-1:0] learn_port_q, learn_port_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [47:0]           wr_data_q, wr_data_d;
    logic                  wr_delete_q, wr_delete_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PORT_WIDTH-1:0] port_mem_q [DEPTH];
    logic [PORT_WIDTH-1:0] port_mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] rr_q, rr_d;
    logic [ADDR_WIDTH-1:0] free_addr;
`ifdef MAC_LEARN_AGING_EN
    logic [DEPTH-1:0]      hit_q, hit_d;
    logic [31:0]           age_cnt_q, age_cnt_d;
    logic                  age_active_q, age_active_d;
    logic [ADDR_WIDTH-1:0] age_addr_q, age_addr_d;
`endif

    // Lowest free slot: scanning downward lets the lowest index win.
    always_comb begin
        free_addr = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_addr = ADDR_WIDTH'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        cmp_data_d   = cmp_data_q;
        learn_port_d = learn_port_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_delete_d  = wr_delete_q;
        valid_d      = valid_q;
        port_mem_d   = port_mem_q;
        rr_d         = rr_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = 1'b0;
        resp_port_d  = '0;
`ifdef MAC_LEARN_AGING_EN
        hit_d        = hit_q;
        age_addr_d   = age_addr_q;
        age_active_d = age_active_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ready_q && lookup_valid) begin
                    op_d       = OP_LOOKUP;
                    cmp_data_d = lookup_mac;
                    cnt_d      = '0;
                    state_d    = S_CMP;
                end else if (ready_q && learn_valid) begin
                    op_d         = OP_LEARN;
                    cmp_data_d   = learn_mac;
                    learn_port_d = learn_port;
                    cnt_d        = '0;
                    state_d      = S_CMP;
                end
`ifdef MAC_LEARN_AGING_EN
                else if (ready_q && age_active_q) begin
                    state_d = S_AGE;
                end
`endif
            end
            S_CMP: begin
                if (cnt_q == CNT_W'(CAM_MATCH_LATENCY - 1)) state_d = S_DECIDE;
                else cnt_d = cnt_q + 1'b1;
            end
            S_DECIDE: begin
                state_d = S_IDLE;
                if (op_q == OP_LOOKUP) begin
                    resp_valid_d = 1'b1;
                    resp_hit_d   = cam_match;
                    resp_port_d  = cam_match ? port_mem_q[cam_match_addr] : '0;
                end else if (cmp_data_q[IG_BIT]) begin
                    state_d = S_IDLE;
                end else if (cam_match) begin
                    port_mem_d[cam_match_addr] = learn_port_q;
`ifdef MAC_LEARN_AGING_EN
                    hit_d[cam_match_addr] = 1'b1;
`endif
                end else begin
                    wr_data_d   = cmp_data_q;
                    wr_delete_d = 1'b0;
                    if (&valid_q) begin
                        wr_addr_d = rr_q;
                        rr_d      = rr_q + 1'b1;
                    end else begin
                        wr_addr_d = free_addr;
                    end
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!cam_write_busy) begin
                    state_d = S_IDLE;
`ifdef MAC_LEARN_AGING_EN
                    if (op_q == OP_AGE) begin
                        valid_d[wr_addr_q] = 1'b0;
                        hit_d[wr_addr_q]   = 1'b0;
                        age_addr_d         = age_addr_q + 1'b1;
                        if (&age_addr_q) age_active_d = 1'b0;
                    end else begin
                        hit_d[wr_addr_q] = 1'b1;
`else
                    begin
`endif
                        valid_d[wr_addr_q]    = 1'b1;
                        port_mem_d[wr_addr_q] = learn_port_q;
                    end
                end
            end
`ifdef MAC_LEARN_AGING_EN
            S_AGE: begin
                if (valid_q[age_addr_q] && !hit_q[age_addr_q]) begin
                    op_d        = OP_AGE;
                    wr_addr_d   = age_addr_q;
                    wr_data_d   = '0;
                    wr_delete_d = 1'b1;
                    state_d     = S_WRITE;
                end else begin
                    hit_d[age_addr_q] = 1'b0;
                    age_addr_d        = age_addr_q + 1'b1;
                    if (&age_addr_q) age_active_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef MAC_LEARN_AGING_EN
        // Period tick last so a new sweep request is never lost to a sweep end.
        age_cnt_d = age_cnt_q + 32'd1;
        if (age_cnt_q == 32'(AGE_PERIOD - 1)) begin
            age_cnt_d    = '0;
            age_active_d = 1'b1;
        end
`endif
        // Ready is a flop: it rises one cycle after the FSM settles in IDLE.
        ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_LOOKUP;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_port_q  <= '0;
            cmp_data_q   <= '0;
            learn_port_q <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_delete_q  <= 1'b0;
            valid_q      <= '0;
            port_mem_q   <= '{default: '0};
            rr_q         <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_port_q  <= resp_port_d;
            cmp_data_q   <= cmp_data_d;
            learn_port_q <= learn_port_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_delete_q  <= wr_delete_d;
            valid_q      <= valid_d;
            port_mem_q   <= port_mem_d;
            rr_q         <= rr_d;
        end
    end

`ifdef MAC_LEARN_AGING_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q        <= '0;
            age_cnt_q    <= '0;
            age_active_q <= 1'b0;
            age_addr_q   <= '0;
        end else begin
            hit_q        <= hit_d;
            age_cnt_q    <= age_cnt_d;
            age_active_q <= age_active_d;
            age_addr_q   <= age_addr_d;
        end
    end
`endif

    assign learn_ready      = ready_q;
    assign lookup_ready     = ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_hit         = resp_hit_q;
    assign resp_port        = resp_port_q;
    assign cam_compare_data = cmp_data_q;
    assign cam_write_addr   = wr_addr_q;
    assign cam_write_data   = wr_data_q;
    assign cam_write_enable = (state_q == S_WRITE);
    assign cam_write_delete = (state_q == S_WRITE) && wr_delete_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_learn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_learn_ctrl
// Brief    : Self-checking bench for mac_learn_ctrl with a behavioural CAM and
//            a dictionary-based forwarding-table reference model.
// Revision : 1.0
// ============================================================================
module tb_mac_learn_ctrl;
    localparam int AW    = 5;
    localparam int PW    = 2;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [47:0]   learn_mac = '0;
    logic [PW-1:0] learn_port = '0;
    logic          learn_valid = 1'b0;
    logic          learn_ready;
    logic [47:0]   lookup_mac = '0;
    logic          lookup_valid = 1'b0;
    logic          lookup_ready;
    logic          resp_valid, resp_hit;
    logic [PW-1:0] resp_port;
    logic [AW-1:0] cam_write_addr;
    logic [47:0]   cam_write_data;
    logic          cam_write_delete, cam_write_enable, cam_write_busy;
    logic [47:0]   cam_compare_data;
    logic          cam_match;
    logic [AW-1:0] cam_match_addr;

    mac_learn_ctrl #(
        .ADDR_WIDTH(AW), .PORT_WIDTH(PW), .CAM_MATCH_LATENCY(1), .AGE_PERIOD(100)
    ) dut (
        .clk(clk), .rst(rst),
        .learn_mac(learn_mac), .learn_port(learn_port),
        .learn_valid(learn_valid), .learn_ready(learn_ready),
        .lookup_mac(lookup_mac), .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_port(resp_port),
        .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
        .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
        .cam_write_busy(cam_write_busy), .cam_compare_data(cam_compare_data),
        .cam_match(cam_match), .cam_match_addr(cam_match_addr)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural CAM: match registered one cycle after compare data, busy for busy_len cycles.
    typedef struct packed { logic del; logic [AW-1:0] addr; logic [47:0] data; } wr_t;
    logic [47:0]    cam_mem [DEPTH];
    logic [DEPTH-1:0] cam_v;
    int             busy_cnt;
    int             busy_len = 1;
    int             wr_cnt = 0;
    wr_t            last_wr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cam_v <= '0; busy_cnt <= 0; cam_match <= 1'b0; cam_match_addr <= '0;
        end else begin
            cam_match <= 1'b0; cam_match_addr <= '0;
            for (int i = 0; i < DEPTH; i++)
                if (cam_v[i] && cam_mem[i] == cam_compare_data) begin
                    cam_match <= 1'b1; cam_match_addr <= AW'(i);
                end
            if (cam_write_enable) begin
                wr_cnt  <= wr_cnt + 1;
                last_wr <= {cam_write_delete, cam_write_addr, cam_write_data};
                cam_v[cam_write_addr]   <= !cam_write_delete;
                cam_mem[cam_write_addr] <= cam_write_data;
                busy_cnt <= busy_len;
            end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        end
    end
    assign cam_write_busy = (busy_cnt > 0);

    // Reference model: a MAC->port dictionary filled in arrival order, then round-robin replacement.
    logic [PW-1:0] ref_port [logic [47:0]];
    logic [47:0]   ref_mac_at [DEPTH];
    int            ref_count = 0;
    int            ref_rr = 0;

    function automatic void model_reset();
        ref_port.delete(); ref_count = 0; ref_rr = 0;
    endfunction

    function automatic void model_learn(input logic [47:0] mac, input logic [PW-1:0] port,
                                        output int exp_nwr, output int exp_addr);
        exp_nwr = 0; exp_addr = 0;
        if (mac[40]) return;
        if (ref_port.exists(mac)) begin ref_port[mac] = port; return; end
        exp_nwr = 1;
        if (ref_count < DEPTH) begin
            exp_addr = ref_count; ref_count++;
        end else begin
            exp_addr = ref_rr;
            ref_port.delete(ref_mac_at[exp_addr]);
            ref_rr = (ref_rr + 1) % DEPTH;
        end
        ref_mac_at[exp_addr] = mac;
        ref_port[mac] = port;
    endfunction

    task automatic drive_learn(input logic [47:0] mac, input logic [PW-1:0] port,
                               output int lat, output int nwr, output bit to);
        int n = 0;
        int w0;
        to = 0; lat = 0; nwr = 0;
        while (!learn_ready && n < 100) begin @(negedge clk); n++; end
        if (!learn_ready) begin to = 1; return; end
        w0 = wr_cnt;
        learn_mac = mac; learn_port = port; learn_valid = 1'b1;
        @(negedge clk);
        learn_valid = 1'b0; lat = 1;
        while (!learn_ready && lat < 200) begin @(negedge clk); lat++; end
        if (!learn_ready) to = 1;
        nwr = wr_cnt - w0;
    endtask

    task automatic drive_lookup(input logic [47:0] mac, output int lat, output logic hit,
                                output logic [PW-1:0] port, output logic rdy_at,
                                output logic rdy_after, output logic rv_after,
                                output int nwr, output bit to);
        int n = 0;
        int w0;
        to = 0; lat = 0; hit = 1'bx; port = 'x; rdy_at = 1'bx; rdy_after = 1'bx;
        rv_after = 1'bx; nwr = 0;
        while (!lookup_ready && n < 100) begin @(negedge clk); n++; end
        if (!lookup_ready) begin to = 1; return; end
        w0 = wr_cnt;
        lookup_mac = mac; lookup_valid = 1'b1;
        @(negedge clk);
        lookup_valid = 1'b0; lat = 1;
        while (!resp_valid && lat < 50) begin @(negedge clk); lat++; end
        if (!resp_valid) begin to = 1; return; end
        hit = resp_hit; port = resp_port; rdy_at = lookup_ready;
        @(negedge clk);
        rdy_after = lookup_ready; rv_after = resp_valid;
        nwr = wr_cnt - w0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({learn_ready, lookup_ready} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_ready: got %b, expected 00", {learn_ready, lookup_ready});
        end
        tests_run++;
        if ({resp_valid, resp_hit, resp_port} !== '0) begin
            tests_failed++; $display("FAIL reset_resp: got %b/%b/%0d, expected 0/0/0", resp_valid, resp_hit, resp_port);
        end
        tests_run++;
        if ({cam_write_enable, cam_write_delete, cam_write_addr, cam_write_data, cam_compare_data} !== '0) begin
            tests_failed++; $display("FAIL reset_cam_outputs: got en=%b del=%b addr=%0d data=%h cmp=%h, expected all 0",
                cam_write_enable, cam_write_delete, cam_write_addr, cam_write_data, cam_compare_data);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (learn_ready !== 1'b0) begin
            tests_failed++; $display("FAIL ready_at_release: got %b, expected 0", learn_ready);
        end
        @(negedge clk);
        tests_run++;
        if ({learn_ready, lookup_ready} !== 2'b11) begin
            tests_failed++; $display("FAIL ready_after_release: got %b, expected 11", {learn_ready, lookup_ready});
        end
        model_reset();
    endtask

    task automatic test_learn_basic();
        logic [47:0] mac = 48'h0011_2233_4455;
        int lat, nwr, en, ea; bit to;
        logic hit, ra, rb, rv; logic [PW-1:0] p;
        model_learn(mac, 2'd2, en, ea);
        drive_learn(mac, 2'd2, lat, nwr, to);
        tests_run++;
        if (to || nwr != 1) begin
            tests_failed++; $display("FAIL learn_basic_write: got writes=%0d timeout=%0d, expected 1/0", nwr, to);
        end
        tests_run++;
        if (last_wr !== {1'b0, AW'(0), mac}) begin
            tests_failed++; $display("FAIL learn_basic_fields: got del=%b addr=%0d data=%h, expected 0/0/%h",
                last_wr.del, last_wr.addr, last_wr.data, mac);
        end
        tests_run++;
        if (lat < 5) begin
            tests_failed++; $display("FAIL learn_basic_ready: got %0d cycles, expected >=5", lat);
        end
        drive_lookup(mac, lat, hit, p, ra, rb, rv, nwr, to);
        tests_run++;
        if (to || lat != 3) begin
            tests_failed++; $display("FAIL lookup_latency: got %0d timeout=%0d, expected 3", lat, to);
        end
        tests_run++;
        if ({hit, p} !== {1'b1, ref_port[mac]}) begin
            tests_failed++; $display("FAIL lookup_hit_port: got %b/%0d, expected 1/%0d", hit, p, ref_port[mac]);
        end
        tests_run++;
        if ({ra, rb, rv} !== 3'b010) begin
            tests_failed++; $display("FAIL lookup_ready_pulse: got rdy_at=%b rdy_after=%b rv_after=%b, expected 0/1/0", ra, rb, rv);
        end
    endtask

    task automatic test_lookup_miss();
        int lat, nwr; bit to; logic hit, ra, rb, rv; logic [PW-1:0] p;
        drive_lookup(48'h0000_0000_0099, lat, hit, p, ra, rb, rv, nwr, to);
        tests_run++;
        if (to || {hit, p} !== {1'b0, 2'd0} || nwr != 0 || lat != 3) begin
            tests_failed++; $display("FAIL lookup_miss: got hit=%b port=%0d writes=%0d lat=%0d, expected 0/0/0/3", hit, p, nwr, lat);
        end
    endtask

    task automatic test_ig_drop();
        int lat, nwr, en, ea; bit to;
        model_learn(48'h0100_5E00_0001, 2'd1, en, ea);
        drive_learn(48'h0100_5E00_0001, 2'd1, lat, nwr, to);
        tests_run++;
        if (to || nwr != en) begin
            tests_failed++; $display("FAIL ig_drop_write: got writes=%0d, expected %0d", nwr, en);
        end
        tests_run++;
        if (lat != 4) begin
            tests_failed++; $display("FAIL ig_drop_ready: got %0d cycles, expected 4", lat);
        end
    endtask

    task automatic test_relearn();
        logic [47:0] mac = 48'h0011_2233_4455;
        int lat, nwr, en, ea; bit to; logic hit, ra, rb, rv; logic [PW-1:0] p;
        model_learn(mac, 2'd3, en, ea);
        drive_learn(mac, 2'd3, lat, nwr, to);
        tests_run++;
        if (to || nwr != 0 || lat != 4) begin
            tests_failed++; $display("FAIL relearn: got writes=%0d lat=%0d, expected 0/4", nwr, lat);
        end
        drive_lookup(mac, lat, hit, p, ra, rb, rv, nwr, to);
        tests_run++;
        if (to || {hit, p} !== {1'b1, 2'd3}) begin
            tests_failed++; $display("FAIL relearn_lookup: got %b/%0d, expected 1/3", hit, p);
        end
    endtask

    task automatic test_fill_evict();
        logic [47:0] mac;
        int lat, nwr, en, ea; bit to; logic hit, ra, rb, rv; logic [PW-1:0] p;
        for (int i = 1; i < DEPTH; i++) begin
            mac = 48'h0200_0000_0000 | 48'(i);
            model_learn(mac, PW'(i), en, ea);
            drive_learn(mac, PW'(i), lat, nwr, to);
            tests_run++;
            if (to || nwr != 1 || last_wr.addr !== AW'(ea)) begin
                tests_failed++; $display("FAIL fill_%0d: got writes=%0d addr=%0d, expected 1/%0d", i, nwr, last_wr.addr, ea);
            end
        end
        for (int k = 0; k < 2; k++) begin
            mac = 48'h02AA_0000_0001 + 48'(k);
            model_learn(mac, 2'd1, en, ea);
            drive_learn(mac, 2'd1, lat, nwr, to);
            tests_run++;
            if (to || nwr != 1 || last_wr.addr !== AW'(k) || last_wr.del !== 1'b0) begin
                tests_failed++; $display("FAIL evict_%0d: got writes=%0d addr=%0d del=%b, expected 1/%0d/0",
                    k, nwr, last_wr.addr, last_wr.del, k);
            end
        end
        drive_lookup(48'h0011_2233_4455, lat, hit, p, ra, rb, rv, nwr, to);
        tests_run++;
        if (to || {hit, p} !== {1'b0, 2'd0}) begin
            tests_failed++; $display("FAIL evicted_lookup: got %b/%0d, expected 0/0", hit, p);
        end
        drive_lookup(48'h02AA_0000_0002, lat, hit, p, ra, rb, rv, nwr, to);
        tests_run++;
        if (to || {hit, p} !== {1'b1, 2'd1}) begin
            tests_failed++; $display("FAIL new_entry_lookup: got %b/%0d, expected 1/1", hit, p);
        end
    endtask

    task automatic test_busy_hold();
        logic [47:0] mac = 48'h02BB_0000_0001;
        int lat = 0, en, ea, w0, busy_seen = 0, viol = 0, n = 0;
        busy_len = 10;
        model_learn(mac, 2'd2, en, ea);
        while (!learn_ready && n < 100) begin @(negedge clk); n++; end
        w0 = wr_cnt;
        learn_mac = mac; learn_port = 2'd2; learn_valid = 1'b1;
        @(negedge clk);
        learn_valid = 1'b0; lat = 1;
        while (!learn_ready && lat < 100) begin
            @(negedge clk); lat++;
            if (cam_write_busy) begin
                busy_seen++;
                if (learn_ready || lookup_ready) viol++;
            end
        end
        tests_run++;
        if (viol != 0 || busy_seen != 10) begin
            tests_failed++; $display("FAIL busy_hold: got violations=%0d busy_cycles=%0d, expected 0/10", viol, busy_seen);
        end
        tests_run++;
        if (!learn_ready || lat < 15 || wr_cnt - w0 != 1 || last_wr.addr !== AW'(ea)) begin
            tests_failed++; $display("FAIL busy_release: got lat=%0d writes=%0d addr=%0d, expected >=15/1/%0d",
                lat, wr_cnt - w0, last_wr.addr, ea);
        end
        busy_len = 1;
    endtask

    task automatic test_reset_mid();
        int n = 0, lat, nwr, en, ea; bit to; logic hit, ra, rb, rv; logic [PW-1:0] p;
        while (!learn_ready && n < 100) begin @(negedge clk); n++; end
        learn_mac = 48'h02CC_0000_0001; learn_port = 2'd3; learn_valid = 1'b1;
        @(negedge clk);
        learn_valid = 1'b0; n = 0;
        while (!cam_write_enable && n < 20) begin @(negedge clk); n++; end
        tests_run++;
        if (!cam_write_enable) begin
            tests_failed++; $display("FAIL mid_reset_reach_write: got en=0 after %0d cycles, expected 1", n);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({cam_write_enable, learn_ready} !== 2'b00) begin
            tests_failed++; $display("FAIL mid_reset_abort: got en=%b ready=%b, expected 0/0", cam_write_enable, learn_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        model_learn(48'h02DD_0000_0001, 2'd1, en, ea);
        drive_learn(48'h02DD_0000_0001, 2'd1, lat, nwr, to);
        tests_run++;
        if (to || nwr != 1 || last_wr.addr !== AW'(0)) begin
            tests_failed++; $display("FAIL post_reset_alloc: got writes=%0d addr=%0d, expected 1/0", nwr, last_wr.addr);
        end
        drive_lookup(48'h02CC_0000_0001, lat, hit, p, ra, rb, rv, nwr, to);
        tests_run++;
        if (to || {hit, p} !== {1'b0, 2'd0}) begin
            tests_failed++; $display("FAIL aborted_mac_lookup: got %b/%0d, expected 0/0", hit, p);
        end
    endtask

    task automatic test_random();
        logic [47:0] mac;
        logic [PW-1:0] port, p, ep;
        int lat, nwr, en, ea, r; bit to; logic hit, ra, rb, rv, eh;
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 9);
            mac = {16'($urandom), 32'($urandom)};
            mac[40] = 1'b0;
            if (r == 5) mac[40] = 1'b1;
            if ((r == 6 || r >= 8) && ref_count > 0) mac = ref_mac_at[$urandom_range(0, ref_count - 1)];
            port = PW'($urandom);
            if (r <= 6) begin
                model_learn(mac, port, en, ea);
                drive_learn(mac, port, lat, nwr, to);
                tests_run++;
                if (to || nwr != en || (en == 1 && last_wr !== {1'b0, AW'(ea), mac}) || (en == 0 && lat != 4)) begin
                    tests_failed++; $display("FAIL rand_learn_%0d: got writes=%0d addr=%0d lat=%0d, expected %0d/%0d",
                        it, nwr, last_wr.addr, lat, en, ea);
                end
            end else begin
                eh = ref_port.exists(mac);
                ep = eh ? ref_port[mac] : '0;
                drive_lookup(mac, lat, hit, p, ra, rb, rv, nwr, to);
                tests_run++;
                if (to || lat != 3 || {hit, p} !== {eh, ep} || nwr != 0) begin
                    tests_failed++; $display("FAIL rand_lookup_%0d: got hit=%b port=%0d lat=%0d, expected %b/%0d/3",
                        it, hit, p, lat, eh, ep);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_learn_basic();
        test_lookup_miss();
        test_ig_drop();
        test_relearn();
        test_fill_evict();
        test_busy_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
